// File: rtl/vga_pkg.sv
// rtl/vga_pkg.sv - shared raster timing constants and generator state type
package vga_pkg;

    // 640x480@60, 25.175 MHz pixel clock, negative syncs
    localparam int VGA640_H_DISPLAY = 640;
    localparam int VGA640_H_FRONT   = 16;
    localparam int VGA640_H_SYNC    = 96;
    localparam int VGA640_H_BACK    = 48;
    localparam int VGA640_V_DISPLAY = 480;
    localparam int VGA640_V_FRONT   = 10;
    localparam int VGA640_V_SYNC    = 2;
    localparam int VGA640_V_BACK    = 33;
    localparam bit VGA640_HSYNC_POL = 1'b0;
    localparam bit VGA640_VSYNC_POL = 1'b0;

    // 800x600@60, 40 MHz pixel clock, positive syncs
    localparam int VGA800_H_DISPLAY = 800;
    localparam int VGA800_H_FRONT   = 40;
    localparam int VGA800_H_SYNC    = 128;
    localparam int VGA800_H_BACK    = 88;
    localparam int VGA800_V_DISPLAY = 600;
    localparam int VGA800_V_FRONT   = 1;
    localparam int VGA800_V_SYNC    = 4;
    localparam int VGA800_V_BACK    = 23;
    localparam bit VGA800_HSYNC_POL = 1'b1;
    localparam bit VGA800_VSYNC_POL = 1'b1;

    // 1024x768@60, 65 MHz pixel clock, negative syncs
    localparam int VGA1024_H_DISPLAY = 1024;
    localparam int VGA1024_H_FRONT   = 24;
    localparam int VGA1024_H_SYNC    = 136;
    localparam int VGA1024_H_BACK    = 160;
    localparam int VGA1024_V_DISPLAY = 768;
    localparam int VGA1024_V_FRONT   = 3;
    localparam int VGA1024_V_SYNC    = 6;
    localparam int VGA1024_V_BACK    = 29;
    localparam bit VGA1024_HSYNC_POL = 1'b0;
    localparam bit VGA1024_VSYNC_POL = 1'b0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } vga_state_t;

    function automatic int vga_total(input int display, input int front,
                                     input int sync, input int back);
        return display + front + sync + back;
    endfunction

endpackage

// File: rtl/vga_timing_gen_if.sv
// rtl/vga_timing_gen_if.sv - raster timing bus; VGA_TIMING_FRAME_CNT_EN adds frame_cnt
interface vga_timing_gen_if #(
    parameter int POS_W = 12
);
    logic             en;
    logic             pix_ce;
    logic             h_sync;
    logic             v_sync;
    logic             display_on;
    logic [POS_W-1:0] h_pos;
    logic [POS_W-1:0] v_pos;
    logic             line_start;
    logic             frame_start;
    logic             running;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0]      frame_cnt;

    modport master (
        input  en,
        output pix_ce, h_sync, v_sync, display_on, h_pos, v_pos,
               line_start, frame_start, running, frame_cnt
    );

    modport slave (
        output en,
        input  pix_ce, h_sync, v_sync, display_on, h_pos, v_pos,
               line_start, frame_start, running, frame_cnt
    );
`else
    modport master (
        input  en,
        output pix_ce, h_sync, v_sync, display_on, h_pos, v_pos,
               line_start, frame_start, running
    );

    modport slave (
        output en,
        input  pix_ce, h_sync, v_sync, display_on, h_pos, v_pos,
               line_start, frame_start, running
    );
`endif

endinterface

// File: rtl/vga_pix_div.sv
// rtl/vga_pix_div.sv - clk-to-pixel divider producing a one-clk-wide pix_ce every DIV clks
module vga_pix_div #(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst,
    output logic pix_ce
);
    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    if (DIV < 1) begin : g_div_chk
        $error("vga_pix_div: DIV must be at least 1");
    end

    logic [CW-1:0] div_cnt;
    logic [CW-1:0] div_nxt;

    always_comb begin
        div_nxt = (div_cnt == LAST) ? '0 : div_cnt + CW'(1);
    end

    // pix_ce is registered from the next count so it is high exactly while div_cnt == LAST
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            div_cnt <= '0;
            pix_ce  <= 1'b0;
        end else begin
            div_cnt <= div_nxt;
            pix_ce  <= (div_nxt == LAST);
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - parametrised raster timing generator with frame-aligned run/stop
// Define VGA_TIMING_FRAME_CNT_EN to add the completed-frame counter on bus.frame_cnt.
module vga_timing_gen
    import vga_pkg::*;
#(
    parameter int H_DISPLAY = VGA640_H_DISPLAY,
    parameter int H_FRONT   = VGA640_H_FRONT,
    parameter int H_SYNC    = VGA640_H_SYNC,
    parameter int H_BACK    = VGA640_H_BACK,
    parameter int V_DISPLAY = VGA640_V_DISPLAY,
    parameter int V_FRONT   = VGA640_V_FRONT,
    parameter int V_SYNC    = VGA640_V_SYNC,
    parameter int V_BACK    = VGA640_V_BACK,
    parameter bit HSYNC_POL = VGA640_HSYNC_POL,
    parameter bit VSYNC_POL = VGA640_VSYNC_POL,
    parameter int POS_W     = 12,
    parameter int PIX_DIV   = 1
) (
    input  logic             clk,
    input  logic             rst,
    vga_timing_gen_if.master bus
);
    localparam int H_TOTAL      = vga_total(H_DISPLAY, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL      = vga_total(V_DISPLAY, V_FRONT, V_SYNC, V_BACK);
    localparam int H_SYNC_START = H_DISPLAY + H_FRONT;
    localparam int H_SYNC_END   = H_SYNC_START + H_SYNC;
    localparam int V_SYNC_START = V_DISPLAY + V_FRONT;
    localparam int V_SYNC_END   = V_SYNC_START + V_SYNC;
    localparam logic [POS_W-1:0] H_LAST = POS_W'(H_TOTAL - 1);
    localparam logic [POS_W-1:0] V_LAST = POS_W'(V_TOTAL - 1);

    if (64'(H_TOTAL - 1) >= (64'd1 << POS_W)) begin : g_h_range_chk
        $error("vga_timing_gen: H_TOTAL-1 does not fit in POS_W bits");
    end
    if (64'(V_TOTAL - 1) >= (64'd1 << POS_W)) begin : g_v_range_chk
        $error("vga_timing_gen: V_TOTAL-1 does not fit in POS_W bits");
    end
    if (PIX_DIV < 1) begin : g_div_chk
        $error("vga_timing_gen: PIX_DIV must be at least 1");
    end

    logic pix_ce;

    vga_pix_div #(
        .DIV(PIX_DIV)
    ) u_pix_div (
        .clk    (clk),
        .rst    (rst),
        .pix_ce (pix_ce)
    );

    vga_state_t       state;
    logic [POS_W-1:0] h_cnt;
    logic [POS_W-1:0] v_cnt;
    logic             h_last;
    logic             v_last;
    logic             at_origin;
    logic             hs_act;
    logic             vs_act;
    logic             de_nxt;
    logic             advance;

    logic             h_sync_q;
    logic             v_sync_q;
    logic             display_on_q;
    logic [POS_W-1:0] h_pos_q;
    logic [POS_W-1:0] v_pos_q;
    logic             line_start_q;
    logic             frame_start_q;
    logic             running_q;

    // h_cnt/v_cnt hold the position that the next tick will present
    always_comb begin
        h_last    = (h_cnt == H_LAST);
        v_last    = (v_cnt == V_LAST);
        at_origin = (h_cnt == '0) && (v_cnt == '0);
        hs_act    = (int'(h_cnt) >= H_SYNC_START) && (int'(h_cnt) < H_SYNC_END);
        vs_act    = (int'(v_cnt) >= V_SYNC_START) && (int'(v_cnt) < V_SYNC_END);
        de_nxt    = (int'(h_cnt) < H_DISPLAY) && (int'(v_cnt) < V_DISPLAY);
        advance   = 1'b1;
        case (state)
            IDLE:    advance = bus.en;
            DRAIN:   advance = bus.en || !at_origin;
            default: advance = 1'b1;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            h_cnt         <= '0;
            v_cnt         <= '0;
            h_sync_q      <= ~HSYNC_POL;
            v_sync_q      <= ~VSYNC_POL;
            display_on_q  <= 1'b0;
            h_pos_q       <= '0;
            v_pos_q       <= '0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            running_q     <= 1'b0;
        end else if (pix_ce) begin
            if (advance) begin
                state         <= bus.en ? RUN : DRAIN;
                h_pos_q       <= h_cnt;
                v_pos_q       <= v_cnt;
                h_sync_q      <= hs_act ? HSYNC_POL : ~HSYNC_POL;
                v_sync_q      <= vs_act ? VSYNC_POL : ~VSYNC_POL;
                display_on_q  <= de_nxt;
                line_start_q  <= (h_cnt == '0);
                frame_start_q <= at_origin;
                running_q     <= 1'b1;
                if (h_last) begin
                    h_cnt <= '0;
                    v_cnt <= v_last ? '0 : v_cnt + POS_W'(1);
                end else begin
                    h_cnt <= h_cnt + POS_W'(1);
                end
            end else begin
                // only reached from IDLE or at a frame boundary, so counters are already 0,0
                state         <= IDLE;
                h_cnt         <= '0;
                v_cnt         <= '0;
                h_sync_q      <= ~HSYNC_POL;
                v_sync_q      <= ~VSYNC_POL;
                display_on_q  <= 1'b0;
                h_pos_q       <= '0;
                v_pos_q       <= '0;
                line_start_q  <= 1'b0;
                frame_start_q <= 1'b0;
                running_q     <= 1'b0;
            end
        end
    end

    assign bus.pix_ce      = pix_ce;
    assign bus.h_sync      = h_sync_q;
    assign bus.v_sync      = v_sync_q;
    assign bus.display_on  = display_on_q;
    assign bus.h_pos       = h_pos_q;
    assign bus.v_pos       = v_pos_q;
    assign bus.line_start  = line_start_q;
    assign bus.frame_start = frame_start_q;
    assign bus.running     = running_q;

`ifdef VGA_TIMING_FRAME_CNT_EN
    logic [15:0] frame_cnt_q;

    // counts the tick that presents the last pixel of a frame, including a draining frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            frame_cnt_q <= '0;
        end else if (pix_ce && advance && h_last && v_last) begin
            frame_cnt_q <= frame_cnt_q + 16'd1;
        end
    end

    assign bus.frame_cnt = frame_cnt_q;
`endif

endmodule
